// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit hex display scanner.
package disp_pkg;

  localparam int DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] dig_idx_t;

  // Digit 0 is never zero-blanked so a zero value still shows "0".
  function automatic logic [DIGITS-1:0] vis_f(
    input logic [15:0] v,
    input logic [3:0]  en,
    input logic        lz
  );
    vis_f[0] = en[0];
    vis_f[1] = en[1] & ~(lz & (v[15:4] == '0));
    vis_f[2] = en[2] & ~(lz & (v[15:8] == '0));
    vis_f[3] = en[3] & ~(lz & (v[15:12] == '0));
  endfunction

endpackage

// File: rtl/disp_if.sv
// Display bus toward the hex-to-7-segment decoder and the digit anodes.
interface disp_if;
  logic [3:0] hex;
  logic       point;
  logic       le;
  logic [3:0] an;

  modport master (output hex, output point, output le, output an);
  modport slave  (input hex, input point, input le, input an);
endinterface

// File: rtl/disp_slot_timer.sv
// Slot timer: per-slot cycle counter and digit index, with
// look-ahead outputs so the caller can register aligned outputs.
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter int TICK_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1024
) (
  input  logic     clk,
  input  logic     rst,
  output logic     frame_start_o,
  output dig_idx_t dig_nxt_o,
  output logic     guard_nxt_o
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] GLIM = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  dig_idx_t      dig_q, dig_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    dig_d = wrap ? dig_q + 2'd1 : dig_q;
    if (rst) begin
      cnt_d = '0;
      dig_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    dig_q <= dig_d;
  end

  assign frame_start_o = (cnt_q == '0) && (dig_q == '0);
  assign dig_nxt_o     = dig_d;
  assign guard_nxt_o   = (cnt_d < GLIM);

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 4-digit hex display scanner with guard interval,
// per-digit enables and leading-zero blanking.
module disp_scan
  import disp_pkg::*;
#(
  parameter int TICK_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_mask,
  input  logic        lzb,
  disp_if.master      bus
);

  logic        frame_start;
  dig_idx_t    dig_nxt;
  logic        guard_nxt;

  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  en_q, en_d;
  logic        lzb_q, lzb_d;

  logic [3:0]  hex_q, hex_d;
  logic        point_q, point_d;
  logic        le_q, le_d;
  logic [3:0]  an_q, an_d;

  logic [DIGITS-1:0] vis;
  logic              show;

  disp_slot_timer #(
    .TICK_CYCLES  (TICK_CYCLES),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .frame_start_o (frame_start),
    .dig_nxt_o     (dig_nxt),
    .guard_nxt_o   (guard_nxt)
  );

  // Outputs are computed from next-state so they line up with cnt/dig.
  always_comb begin
    value_d = frame_start ? value   : value_q;
    dp_d    = frame_start ? dp_in   : dp_q;
    en_d    = frame_start ? en_mask : en_q;
    lzb_d   = frame_start ? lzb     : lzb_q;
    vis     = vis_f(value_d, en_d, lzb_d);
    show    = !guard_nxt && vis[dig_nxt];
    hex_d   = value_d[{dig_nxt, 2'b00} +: 4];
    point_d = show & dp_d[dig_nxt];
    le_d    = !show;
    an_d    = show ? ~(4'b0001 << dig_nxt) : AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      lzb_q   <= 1'b0;
      hex_q   <= '0;
      point_q <= 1'b0;
      le_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      value_q <= value_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      lzb_q   <= lzb_d;
      hex_q   <= hex_d;
      point_q <= point_d;
      le_q    <= le_d;
      an_q    <= an_d;
    end
  end

  assign bus.hex   = hex_q;
  assign bus.point = point_q;
  assign bus.le    = le_q;
  assign bus.an    = an_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with an 8-cycle slot and 2-cycle guard.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'hDEAD;
  logic [3:0]  dp_in = 4'hF;
  logic [3:0]  en_mask = 4'hF;
  logic        lzb = 1'b1;

  int npass = 0;
  int ntot  = 0;

  disp_if u_if();

  disp_scan #(
    .TICK_CYCLES  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .dp_in   (dp_in),
    .en_mask (en_mask),
    .lzb     (lzb),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic chk_rst_out(input string tg);
    chk({tg, ".an"}, 16'(u_if.an), 16'hF);
    chk({tg, ".le"}, 16'(u_if.le), 16'h1);
    chk({tg, ".hex"}, 16'(u_if.hex), 16'h0);
    chk({tg, ".pt"}, 16'(u_if.point), 16'h0);
  endtask

  // Hold reset for 3 checked cycles; next negedge is cycle 0.
  task automatic do_reset(input string tg);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_rst_out(tg);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // v: displayed value, anv: show-window anode per slot, pt: dp request.
  task automatic run(input string tg, input int start, input int n,
                     input logic [15:0] v, input logic [15:0] anv,
                     input logic [3:0] pt);
    int slot, ph;
    logic [3:0] ea;
    logic ep;
    for (int c = start; c < start + n; c++) begin
      @(negedge clk);
      slot = (c / 8) % 4;
      ph   = c % 8;
      if (ph < 2) begin
        ea = 4'hF;
        ep = 1'b0;
      end else begin
        ea = anv[slot*4 +: 4];
        ep = (ea != 4'hF) ? pt[slot] : 1'b0;
      end
      chk($sformatf("%s.an.c%0d", tg, c), 16'(u_if.an), 16'(ea));
      chk($sformatf("%s.le.c%0d", tg, c), 16'(u_if.le),
          16'(ea == 4'hF));
      chk($sformatf("%s.pt.c%0d", tg, c), 16'(u_if.point), 16'(ep));
      if (c % 32 != 0)
        chk($sformatf("%s.hex.c%0d", tg, c), 16'(u_if.hex),
            16'(v[slot*4 +: 4]));
    end
  endtask

  initial begin
    do_reset("rst");

    value = 16'h12AB; dp_in = 4'b0100; en_mask = 4'hF; lzb = 1'b0;
    do_reset("t2r");
    run("t2", 0, 32, 16'h12AB, 16'h7BDE, 4'b0100);
    run("t2w", 0, 2, 16'h12AB, 16'h7BDE, 4'b0100);

    value = 16'h0050; dp_in = 4'b0000; lzb = 1'b1;
    do_reset("t3r");
    run("t3a", 0, 32, 16'h0050, 16'hFFDE, 4'b0000);
    value = 16'h0000;
    do_reset("t3r2");
    run("t3b", 0, 32, 16'h0000, 16'hFFFE, 4'b0000);

    value = 16'h1234; lzb = 1'b0;
    do_reset("t4r");
    run("t4a", 0, 12, 16'h1234, 16'h7BDE, 4'b0000);
    value = 16'h5678;
    run("t4b", 12, 20, 16'h1234, 16'h7BDE, 4'b0000);
    run("t4c", 32, 32, 16'h5678, 16'h7BDE, 4'b0000);

    en_mask = 4'b0000; value = 16'h1234;
    do_reset("t5r");
    run("t5", 0, 32, 16'h1234, 16'hFFFF, 4'b0000);

    en_mask = 4'hF; value = 16'h12AB; dp_in = 4'b0100;
    do_reset("t6r");
    run("t6a", 0, 20, 16'h12AB, 16'h7BDE, 4'b0100);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6.c20.an", 16'(u_if.an), 16'hB);
    chk("t6.c20.hex", 16'(u_if.hex), 16'h2);
    @(posedge clk);
    #1 rst = 1'b0;
    run("t6b", 0, 16, 16'h12AB, 16'h7BDE, 4'b0100);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
